// File: rtl/snitch_ro_cache_ar_router.sv
// AR steering for the read-only cache: rule decode, per-ID ordering tracker,
// outstanding-transaction bound and flush drain interlock.

module snitch_ro_cache_ar_router_trk #(
  parameter int unsigned CntW = 3,
  parameter int unsigned PW   = 2,
  parameter int unsigned DecW = 2
)(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic [DecW-1:0] dec_i,
  input  logic [PW-1:0]   port_i,
  output logic [CntW-1:0] cnt_o,
  output logic [PW-1:0]   port_o,
  output logic            err_o
);
  localparam int unsigned SW = CntW + DecW + 1;

  logic [CntW-1:0] r_cnt;
  logic [PW-1:0]   r_port;
  logic [SW-1:0]   w_sum, w_dec, w_nxt;
  logic            w_err;

  // Underflow is a protocol error; the count clamps at zero.
  always_comb begin
    w_sum = SW'(r_cnt) + SW'(inc_i);
    w_dec = SW'(dec_i);
    w_err = w_sum < w_dec;
    w_nxt = w_err ? '0 : w_sum - w_dec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_port <= '0;
    end else begin
      r_cnt <= CntW'(w_nxt);
      if (inc_i) r_port <= port_i;
    end
  end

  assign cnt_o  = r_cnt;
  assign port_o = r_port;
  assign err_o  = w_err;
endmodule

module snitch_ro_cache_ar_router #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiIdWidth   = 2,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned NrPorts      = 3,
  parameter int unsigned NrAddrRules  = 2,
  parameter int unsigned MaxTrans     = 4,
  localparam int unsigned PW          = $clog2(NrPorts),
  localparam int unsigned IW          = AxiIdWidth,
  localparam int unsigned AW          = AxiAddrWidth
)(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic [NrAddrRules*AW-1:0] start_addr_i,
  input  logic [NrAddrRules*AW-1:0] end_addr_i,
  input  logic [NrAddrRules*PW-1:0] rule_port_i,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AW-1:0]             ar_addr_i,
  input  logic [IW-1:0]             ar_id_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  input  logic                      ar_lock_i,
  output logic [NrPorts-1:0]        mst_ar_valid_o,
  input  logic [NrPorts-1:0]        mst_ar_ready_i,
  output logic [PW-1:0]             ar_sel_o,
  input  logic [NrPorts-1:0]        done_valid_i,
  input  logic [NrPorts*IW-1:0]     done_id_i,
  input  logic                      flush_valid_i,
  output logic                      flush_ready_o,
  output logic                      cache_flush_valid_o,
  input  logic                      cache_flush_ready_i
);
  localparam int unsigned NumIds   = 2**AxiIdWidth;
  localparam int unsigned CntW     = $clog2(MaxTrans+1);
  localparam int unsigned DecW     = $clog2(NrPorts+1);
  localparam int unsigned FullSize = $clog2(AxiDataWidth/8);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, ACK} state_e;

  state_e                        r_state;
  logic                          r_cache_flush_valid, r_flush_ready;
  logic                          r_waiting, r_presented;
  logic [PW-1:0]                 r_sel;

  logic                          w_hit, w_force;
  logic [PW-1:0]                 w_rule_port, w_dec_sel, w_sel;
  logic [NumIds-1:0][CntW-1:0]   w_cnt;
  logic [NumIds-1:0][PW-1:0]     w_port;
  logic [NumIds-1:0][DecW-1:0]   w_dec;
  logic [NumIds-1:0]             w_err;
  logic [CntW-1:0]               w_cur_cnt;
  logic [PW-1:0]                 w_cur_port;
  logic                          w_stall, w_mst_valid, w_hs, w_drained;

  // First matching rule wins; anything the caches cannot serve goes to bypass.
  always_comb begin
    w_hit       = 1'b0;
    w_rule_port = '0;
    for (int r = 0; r < NrAddrRules; r++) begin
      if (!w_hit && ar_addr_i >= start_addr_i[r*AW +: AW] &&
          ar_addr_i < end_addr_i[r*AW +: AW]) begin
        w_hit       = 1'b1;
        w_rule_port = rule_port_i[r*PW +: PW];
      end
    end
    w_force = !enable_i || ar_lock_i || (ar_burst_i == 2'b10) ||
              (ar_len_i != 8'd0 && ar_size_i < 3'(FullSize)) || !w_hit ||
              ({1'b0, w_rule_port} >= (PW+1)'(NrPorts));
    w_dec_sel = w_force ? '0 : w_rule_port;
  end

  assign w_sel      = r_waiting ? r_sel : w_dec_sel;
  assign w_cur_cnt  = w_cnt[ar_id_i];
  assign w_cur_port = w_port[ar_id_i];

  // An AR already shown downstream is never withdrawn.
  assign w_stall = !r_presented &&
                   ((w_cur_cnt != '0 && w_cur_port != w_sel) ||
                    (w_cur_cnt == CntW'(MaxTrans)) ||
                    (r_state != IDLE && w_sel != '0));

  assign w_mst_valid    = ar_valid_i && !w_stall;
  assign w_hs           = w_mst_valid && mst_ar_ready_i[w_sel];
  assign mst_ar_valid_o = w_mst_valid ? (NrPorts'(1) << w_sel) : '0;
  assign ar_ready_o     = w_hs;
  assign ar_sel_o       = w_sel;

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NumIds; i++)
      for (int p = 0; p < NrPorts; p++)
        if (done_valid_i[p] && done_id_i[p*IW +: IW] == IW'(i))
          w_dec[i] = w_dec[i] + DecW'(1);
  end

  for (genvar g = 0; g < NumIds; g++) begin : g_trk
    snitch_ro_cache_ar_router_trk #(.CntW(CntW), .PW(PW), .DecW(DecW)) u_trk (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_hs && ar_id_i == IW'(g)),
      .dec_i  (w_dec[g]),
      .port_i (w_sel),
      .cnt_o  (w_cnt[g]),
      .port_o (w_port[g]),
      .err_o  (w_err[g])
    );
  end

  always_comb begin
    w_drained = 1'b1;
    for (int i = 0; i < NumIds; i++)
      if (w_port[i] != '0 && w_cnt[i] != '0) w_drained = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_waiting   <= 1'b0;
      r_presented <= 1'b0;
      r_sel       <= '0;
    end else begin
      r_waiting   <= ar_valid_i && !w_hs;
      r_presented <= w_mst_valid && !w_hs;
      r_sel       <= w_sel;
    end
  end

  // A cache AR accepted in the drain cycle (held-over presentation) must
  // still be waited for before the flush goes out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state             <= IDLE;
      r_cache_flush_valid <= 1'b0;
      r_flush_ready       <= 1'b0;
    end else begin
      case (r_state)
        IDLE:  if (flush_valid_i) r_state <= DRAIN;
        DRAIN: if (w_drained && !(w_hs && w_sel != '0)) begin
          r_state             <= FLUSH;
          r_cache_flush_valid <= 1'b1;
        end
        FLUSH: if (cache_flush_ready_i) begin
          r_state             <= ACK;
          r_cache_flush_valid <= 1'b0;
          r_flush_ready       <= 1'b1;
        end
        default: begin
          r_state       <= IDLE;
          r_flush_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cache_flush_valid_o = r_cache_flush_valid;
  assign flush_ready_o       = r_flush_ready;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) w_err == '0);
endmodule
